// File: rtl/pcs_pkg.sv
// Shared constants and types for the lite 10GBASE-R PCS encoder/decoder pair.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BLOCK_TYPE_IDLE   = 8'h1e;
  localparam logic [7:0] BLOCK_TYPE_START0 = 8'h78;
  localparam logic [7:0] BLOCK_TYPE_START4 = 8'h33;
  localparam logic [7:0] BLOCK_TYPE_TERM0  = 8'h87;
  localparam logic [7:0] BLOCK_TYPE_TERM1  = 8'h99;
  localparam logic [7:0] BLOCK_TYPE_TERM2  = 8'haa;
  localparam logic [7:0] BLOCK_TYPE_TERM3  = 8'hb4;
  localparam logic [7:0] BLOCK_TYPE_TERM4  = 8'hcc;
  localparam logic [7:0] BLOCK_TYPE_TERM5  = 8'hd2;
  localparam logic [7:0] BLOCK_TYPE_TERM6  = 8'he1;
  localparam logic [7:0] BLOCK_TYPE_TERM7  = 8'hff;

  localparam logic [6:0] CTRL_IDLE = 7'h07;

  localparam logic [7:0] XGMII_START = 8'hfb;
  localparam logic [7:0] XGMII_TERM  = 8'hfd;
  localparam logic [7:0] XGMII_ERR   = 8'hfe;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;

  typedef enum logic [3:0] {
    RX_INIT = 4'b0001,
    RX_C    = 4'b0010,
    RX_D    = 4'b0100,
    RX_E    = 4'b1000
  } rx_state_e;

  typedef struct packed {
    logic       data;
    logic       idle;
    logic [1:0] start;
    logic       term;
    logic [2:0] term_k;
    logic       invalid;
  } blk_class_t;

  // {hit, k}: k is the number of data bytes carried by a terminate block
  function automatic logic [3:0] term_lookup(input logic [7:0] t);
    case (t)
      BLOCK_TYPE_TERM0: return 4'b1_000;
      BLOCK_TYPE_TERM1: return 4'b1_001;
      BLOCK_TYPE_TERM2: return 4'b1_010;
      BLOCK_TYPE_TERM3: return 4'b1_011;
      BLOCK_TYPE_TERM4: return 4'b1_100;
      BLOCK_TYPE_TERM5: return 4'b1_101;
      BLOCK_TYPE_TERM6: return 4'b1_110;
      BLOCK_TYPE_TERM7: return 4'b1_111;
      default:          return 4'b0_000;
    endcase
  endfunction

endpackage

// File: rtl/pcs_dec_blk_type.sv
// Combinational block classifier: sync header + payload -> block class.
module pcs_dec_blk_type import pcs_pkg::*; #(
  parameter int DATA_W       = 64,
  parameter int BLOCK_TYPE_W = 8
) (
  input  logic [1:0]        sync_head,
  input  logic [DATA_W-1:0] data,
  output blk_class_t        cls
);

  logic [7:0] c_idle;
  logic       term_hit;
  logic [2:0] term_k;

  // eight 7-bit control codes follow the type byte
  for (genvar i = 0; i < 8; i++) begin : g_c
    assign c_idle[i] = (data[BLOCK_TYPE_W + 7*i +: 7] == CTRL_IDLE);
  end

  assign {term_hit, term_k} = term_lookup(data[BLOCK_TYPE_W-1:0]);

  always_comb begin
    cls = '0;
    case (sync_head)
      SYNC_DATA: cls.data = 1'b1;
      SYNC_CTRL: begin
        case (data[BLOCK_TYPE_W-1:0])
          BLOCK_TYPE_IDLE: begin
            cls.idle    = &c_idle;
            cls.invalid = ~&c_idle;
          end
          BLOCK_TYPE_START0: cls.start = 2'b01;
          BLOCK_TYPE_START4: cls.start = 2'b10;
          default: begin
            cls.term    = term_hit;
            cls.term_k  = term_k;
            cls.invalid = ~term_hit;
          end
        endcase
      end
      default: cls.invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/pcs_dec_lite.sv
// 10GBASE-R lite receive decoder: block classify, rx FSM, lane mux, error count.
module pcs_dec_lite import pcs_pkg::*; #(
  parameter int DATA_W       = 64,
  parameter int KEEP_W       = DATA_W/8,
  parameter int BLOCK_TYPE_W = 8,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 head_v_i,
  input  logic [1:0]           sync_head_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic                 valid_o,
  output logic                 ctrl_v_o,
  output logic                 idle_v_o,
  output logic [1:0]           start_o,
  output logic                 term_o,
  output logic                 err_o,
  output logic [DATA_W-1:0]    data_o,
  output logic [KEEP_W-1:0]    keep_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  blk_class_t cls;
  rx_state_e  state, state_nx;
  logic       err_blk;

  logic [DATA_W-1:0]      shifted;
  logic [KEEP_W-1:0][7:0] term_dat;
  logic [KEEP_W-1:0]      term_keep;
  logic [DATA_W-1:0]      dat_nx;
  logic [KEEP_W-1:0]      keep_nx;
  logic                   idle_nx, term_nx;
  logic [1:0]             start_nx;

  pcs_dec_blk_type #(.DATA_W(DATA_W), .BLOCK_TYPE_W(BLOCK_TYPE_W)) u_blk_type (
    .sync_head (sync_head_i),
    .data      (data_i),
    .cls       (cls)
  );

  // INIT, C and E share the same exits; only D accepts data/terminate
  always_comb begin
    state_nx = state;
    if (cls.invalid) state_nx = RX_E;
    else begin
      case (state)
        RX_INIT, RX_C, RX_E:
          if (|cls.start)   state_nx = RX_D;
          else if (cls.idle) state_nx = RX_C;
          else               state_nx = RX_E;
        RX_D:
          if (cls.data)      state_nx = RX_D;
          else if (cls.term) state_nx = RX_C;
          else               state_nx = RX_E;
        default:             state_nx = RX_E;
      endcase
    end
  end

  assign err_blk = (state_nx == RX_E);

  // terminate: payload bytes drop the type byte, then /T/, then idles
  assign shifted = {8'h00, data_i[DATA_W-1:8]};
  for (genvar i = 0; i < KEEP_W; i++) begin : g_lane
    assign term_dat[i]  = (3'(i) < cls.term_k)  ? shifted[8*i +: 8] :
                          (3'(i) == cls.term_k) ? XGMII_TERM : XGMII_IDLE;
    assign term_keep[i] = (3'(i) < cls.term_k);
  end

  always_comb begin
    dat_nx   = data_i;
    keep_nx  = '1;
    idle_nx  = 1'b0;
    start_nx = 2'b00;
    term_nx  = 1'b0;
    if (err_blk) begin
      dat_nx  = {KEEP_W{XGMII_ERR}};
      keep_nx = '0;
    end else if (cls.idle) begin
      dat_nx  = {KEEP_W{XGMII_IDLE}};
      keep_nx = '0;
      idle_nx = 1'b1;
    end else if (cls.start[0]) begin
      dat_nx   = {data_i[DATA_W-1:8], XGMII_START};
      start_nx = 2'b01;
    end else if (cls.start[1]) begin
      dat_nx   = {data_i[DATA_W-1:40], XGMII_START, {(KEEP_W/2){XGMII_IDLE}}};
      keep_nx  = {{(KEEP_W/2){1'b1}}, {(KEEP_W/2){1'b0}}};
      start_nx = 2'b10;
    end else if (cls.term) begin
      dat_nx  = term_dat;
      keep_nx = term_keep;
      term_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= RX_INIT;
      valid_o   <= 1'b0;
      ctrl_v_o  <= 1'b0;
      idle_v_o  <= 1'b0;
      start_o   <= 2'b00;
      term_o    <= 1'b0;
      err_o     <= 1'b0;
      data_o    <= '0;
      keep_o    <= '0;
      err_cnt_o <= '0;
    end else begin
      valid_o <= head_v_i;
      if (head_v_i) begin
        state    <= state_nx;
        ctrl_v_o <= (sync_head_i == SYNC_CTRL);
        idle_v_o <= idle_nx;
        start_o  <= start_nx;
        term_o   <= term_nx;
        err_o    <= err_blk;
        data_o   <= dat_nx;
        keep_o   <= keep_nx;
        if (err_blk && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pcs_dec_lite.sv
// Directed + randomized bench for pcs_dec_lite against a byte-level reference model.
module tb_pcs_dec_lite;

  logic        clk = 1'b0;
  logic        nreset;
  logic        head_v_i;
  logic [1:0]  sync_head_i;
  logic [63:0] data_i;
  logic        valid_o, ctrl_v_o, idle_v_o, term_o, err_o;
  logic [1:0]  start_o;
  logic [63:0] data_o;
  logic [7:0]  keep_o;
  logic [7:0]  err_cnt_o;

  always #5 clk = ~clk;

  pcs_dec_lite dut (
    .clk         (clk),
    .nreset      (nreset),
    .head_v_i    (head_v_i),
    .sync_head_i (sync_head_i),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ctrl_v_o    (ctrl_v_o),
    .idle_v_o    (idle_v_o),
    .start_o     (start_o),
    .term_o      (term_o),
    .err_o       (err_o),
    .data_o      (data_o),
    .keep_o      (keep_o),
    .err_cnt_o   (err_cnt_o)
  );

  int passed = 0;
  int total  = 0;

  // reference model: only "inside a packet" matters for the next block
  bit          in_pkt;
  logic        ev, ec, ei, et, ee;
  logic [1:0]  es;
  logic [63:0] ed;
  logic [7:0]  ek, ecnt;
  logic [7:0]  term_types [8] = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},  64'(valid_o),   64'(ev));
    chk({tag, ".ctrl_v"}, 64'(ctrl_v_o),  64'(ec));
    chk({tag, ".idle_v"}, 64'(idle_v_o),  64'(ei));
    chk({tag, ".start"},  64'(start_o),   64'(es));
    chk({tag, ".term"},   64'(term_o),    64'(et));
    chk({tag, ".err"},    64'(err_o),     64'(ee));
    chk({tag, ".data"},   data_o,         ed);
    chk({tag, ".keep"},   64'(keep_o),    64'(ek));
    chk({tag, ".errcnt"}, 64'(err_cnt_o), 64'(ecnt));
  endtask

  task automatic model_reset();
    in_pkt = 0;
    {ev, ec, ei, et, ee} = '0;
    es = 0; ed = 0; ek = 0; ecnt = 0;
  endtask

  function automatic logic [63:0] idle_blk();
    logic [63:0] d;
    d = 64'h1e;
    for (int i = 0; i < 8; i++) d |= 64'h07 << (8 + 7*i);
    return d;
  endfunction

  task automatic model(input logic [1:0] s, input logic [63:0] d);
    int   kind;  // 0 data, 1 idle, 2 start0, 3 start4, 4 term, 5 invalid
    int   k;
    bit   err;
    logic [7:0] b [8];
    kind = 5;
    k = 0;
    if (s == 2'b01) kind = 0;
    else if (s == 2'b10) begin
      if (d[7:0] == 8'h1e) begin
        kind = 1;
        for (int i = 0; i < 8; i++) if (((d >> (8 + 7*i)) & 64'h7f) != 64'h07) kind = 5;
      end else if (d[7:0] == 8'h78) kind = 2;
      else if (d[7:0] == 8'h33) kind = 3;
      else for (int i = 0; i < 8; i++) if (d[7:0] == term_types[i]) begin kind = 4; k = i; end
    end
    if (in_pkt) begin
      err    = !(kind == 0 || kind == 4);
      in_pkt = (kind == 0);
    end else begin
      err    = !(kind == 1 || kind == 2 || kind == 3);
      in_pkt = (kind == 2 || kind == 3);
    end
    ev = 1; ec = (s == 2'b10); ei = 0; es = 0; et = 0; ee = 0;
    if (err) begin
      ee = 1; ed = {8{8'hfe}}; ek = 0;
      if (ecnt != 8'hff) ecnt++;
    end else begin
      case (kind)
        0: begin ed = d; ek = 8'hff; end
        1: begin ed = {8{8'h07}}; ek = 8'h00; ei = 1; end
        2: begin ed = {d[63:8], 8'hfb}; ek = 8'hff; es = 2'b01; end
        3: begin ed = {d[63:40], 8'hfb, 32'h07070707}; ek = 8'hf0; es = 2'b10; end
        default: begin
          for (int i = 0; i < 8; i++)
            b[i] = (i < k) ? 8'((d >> (8*i + 8)) & 64'hff) : (i == k) ? 8'hfd : 8'h07;
          ed = {b[7], b[6], b[5], b[4], b[3], b[2], b[1], b[0]};
          ek = 8'((9'd1 << k) - 9'd1);
          et = 1;
        end
      endcase
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [1:0] s, input logic [63:0] d);
    @(negedge clk);
    head_v_i = v; sync_head_i = s; data_i = d;
    if (v) model(s, d);
    else ev = 0;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    head_v_i = 0;
    #2 nreset = 0;
    #1 model_reset();
    check_all("reset");
    @(negedge clk);
    nreset = 1;
  endtask

  logic [63:0] rnd;
  int          r;

  initial begin
    nreset = 1; head_v_i = 0; sync_head_i = 0; data_i = 0;
    model_reset();
    do_reset();

    for (int i = 0; i < 4; i++) step("idle", 1, 2'b10, idle_blk());
    chk("idle_keep", 64'(keep_o), 64'h00);

    step("start0", 1, 2'b10, {56'h07060504030201, 8'h78});
    chk("start0_data", data_o, 64'h07060504030201fb);
    chk("start0_flag", 64'(start_o), 64'h1);
    step("data", 1, 2'b01, {$urandom, $urandom});
    chk("data_keep", 64'(keep_o), 64'hff);
    step("term1", 1, 2'b10, {48'h0, 8'haa, 8'h99});
    chk("term1_data", data_o, 64'h070707070707fdaa);
    chk("term1_keep", 64'(keep_o), 64'h01);

    // terminate then start back to back, lane-4 start
    step("start4", 1, 2'b10, {24'habcdef, 32'h12345678, 8'h33});
    chk("start4_lane4", 64'(data_o[39:32]), 64'hfb);
    chk("start4_err", 64'(err_o), 64'h0);
    step("term0", 1, 2'b10, {56'h0, 8'h87});

    // data directly after idle is errored; idle recovers
    step("idle2", 1, 2'b10, idle_blk());
    step("data_in_c", 1, 2'b01, 64'h1122334455667788);
    chk("err_data", data_o, 64'hfefefefefefefefe);
    chk("err_cnt1", 64'(err_cnt_o), 64'h1);
    step("recover_idle", 1, 2'b10, idle_blk());
    step("recover_start", 1, 2'b10, {$urandom, $urandom_range(0, 255), 8'h78} );

    // gaps mid-frame
    for (int i = 0; i < 3; i++) step("gap", 0, 2'b01, {$urandom, $urandom});
    step("resume_data", 1, 2'b01, {$urandom, $urandom});
    chk("resume_err", 64'(err_o), 64'h0);
    step("resume_term", 1, 2'b10, {$urandom, 24'h0, 8'hff});

    // reset inside a packet
    step("pre_rst_start", 1, 2'b10, {56'h0, 8'h78});
    do_reset();
    step("post_rst_data", 1, 2'b01, {$urandom, $urandom});
    chk("post_rst_err", 64'(err_o), 64'h1);

    for (int n = 0; n < 400; n++) begin
      r   = $urandom_range(0, 11);
      rnd = {$urandom, $urandom};
      case (r)
        0, 1:    step("rnd_idle", 1, 2'b10, idle_blk());
        2:       step("rnd_start0", 1, 2'b10, {rnd[63:8], 8'h78});
        3:       step("rnd_start4", 1, 2'b10, {rnd[63:8], 8'h33});
        4, 5, 6: step("rnd_data", 1, 2'b01, rnd);
        7:       step("rnd_term", 1, 2'b10, {rnd[63:8], term_types[$urandom_range(0, 7)]});
        8:       step("rnd_ctrl", 1, 2'b10, rnd);
        9:       step("rnd_sync", 1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, rnd);
        10:      step("rnd_badidle", 1, 2'b10, idle_blk() ^ (64'h1 << $urandom_range(8, 63)));
        default: step("rnd_gap", 0, 2'(r), rnd);
      endcase
    end

    // saturate the error counter
    step("sat_idle", 1, 2'b10, idle_blk());
    step("sat_start", 1, 2'b10, {56'h0, 8'h78});
    step("sat_sync11", 1, 2'b11, {$urandom, $urandom});
    for (int n = 0; n < 300; n++) step("sat", 1, 2'b00, {$urandom, $urandom});
    chk("sat_cnt", 64'(err_cnt_o), 64'hff);
    chk("sat_err", 64'(err_o), 64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
